// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM stage plus MEM/WB pipeline register. Issues one data-memory access
//   per load/store over a req/ack bus, aligns store bytes onto their lanes,
//   sign-extends loads, and stalls upstream until the access finishes.
//
// Ports
//   Clk, Reset            clock (rising edge), asynchronous active-low reset
//   RegWrite .. PCAddResult  EX/MEM register fields
//   dmem_*                data-memory req/ack bus (outputs registered)
//   Stall                 combinational hold for EX/MEM and upstream
//   *_wb                  MEM/WB register fields
//   align_err, bus_err    one-cycle pulses for dropped / timed-out accesses
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        RegWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        loadhalf,
    input  logic        loadbyte,
    input  logic        storehalf,
    input  logic        storebyte,
    input  logic [1:0]  MemtoReg,
    input  logic [4:0]  RTorRd,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic [31:0] PCAddResult,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        Stall,
    output logic        RegWrite_wb,
    output logic [1:0]  MemtoReg_wb,
    output logic [4:0]  RTorRd_wb,
    output logic [31:0] MemData_wb,
    output logic [31:0] ALUResult_wb,
    output logic [31:0] PCAddResult_wb,
    output logic        align_err,
    output logic        bus_err
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          regwrite_wb_q, regwrite_wb_d;
    logic [1:0]    memtoreg_wb_q, memtoreg_wb_d;
    logic [4:0]    rtorrd_wb_q, rtorrd_wb_d;
    logic [31:0]   memdata_wb_q, memdata_wb_d;
    logic [31:0]   aluresult_wb_q, aluresult_wb_d;
    logic [31:0]   pcaddresult_wb_q, pcaddresult_wb_d;
    logic          align_err_q, align_err_d;
    logic          bus_err_q, bus_err_d;

    logic        mem;
    logic        bad;
    logic        is_half;
    logic        is_byte;
    logic        is_word;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Access size and legality. Size qualifiers come from the load or store
    // set depending on direction; byte takes priority over half.
    always_comb begin
        mem     = MemRead | MemWrite;
        is_byte = MemRead ? loadbyte : storebyte;
        is_half = (MemRead ? loadhalf : storehalf) & ~is_byte;
        is_word = ~is_byte & ~is_half;
        bad     = (MemRead & MemWrite)
                | (is_word & (ALUResult[1:0] != 2'b00))
                | (is_half & ALUResult[0]);
    end

    // Store lane placement and load extraction.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = WriteData;
        if (is_byte) begin
            st_be    = 4'b0001 << ALUResult[1:0];
            st_wdata = {4{WriteData[7:0]}};
        end else if (is_half) begin
            st_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{WriteData[15:0]}};
        end

        ld_byte = dmem_rdata[8*ALUResult[1:0] +: 8];
        ld_half = dmem_rdata[16*ALUResult[1] +: 16];
        if (is_byte) begin
            ld_data = {{24{ld_byte[7]}}, ld_byte};
        end else if (is_half) begin
            ld_data = {{16{ld_half[15]}}, ld_half};
        end else begin
            ld_data = dmem_rdata;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        req_d            = req_q;
        we_d             = we_q;
        addr_d           = addr_q;
        be_d             = be_q;
        wdata_d          = wdata_q;
        regwrite_wb_d    = 1'b0;
        memtoreg_wb_d    = '0;
        rtorrd_wb_d      = '0;
        memdata_wb_d     = '0;
        aluresult_wb_d   = '0;
        pcaddresult_wb_d = '0;
        align_err_d      = 1'b0;
        bus_err_d        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!mem) begin
                    regwrite_wb_d    = RegWrite;
                    memtoreg_wb_d    = MemtoReg;
                    rtorrd_wb_d      = RTorRd;
                    aluresult_wb_d   = ALUResult;
                    pcaddresult_wb_d = PCAddResult;
                end else if (bad) begin
                    align_err_d = 1'b1;
                end else begin
                    req_d   = 1'b1;
                    we_d    = MemWrite;
                    addr_d  = {ALUResult[31:2], 2'b00};
                    be_d    = MemWrite ? st_be : 4'b0000;
                    wdata_d = MemWrite ? st_wdata : '0;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                // EX/MEM is held by Stall, so the instruction fields and the
                // address used for load extraction are still valid here.
                if (dmem_ack) begin
                    req_d            = 1'b0;
                    regwrite_wb_d    = RegWrite & ~MemWrite;
                    memtoreg_wb_d    = MemtoReg;
                    rtorrd_wb_d      = RTorRd;
                    memdata_wb_d     = MemRead ? ld_data : '0;
                    aluresult_wb_d   = ALUResult;
                    pcaddresult_wb_d = PCAddResult;
                    state_d          = S_RESP;
                end else if (TIMEOUT != 0) begin
                    if (cnt_q == CNT_LAST) begin
                        req_d     = 1'b0;
                        bus_err_d = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            req_q            <= 1'b0;
            we_q             <= 1'b0;
            addr_q           <= '0;
            be_q             <= '0;
            wdata_q          <= '0;
            regwrite_wb_q    <= 1'b0;
            memtoreg_wb_q    <= '0;
            rtorrd_wb_q      <= '0;
            memdata_wb_q     <= '0;
            aluresult_wb_q   <= '0;
            pcaddresult_wb_q <= '0;
            align_err_q      <= 1'b0;
            bus_err_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            req_q            <= req_d;
            we_q             <= we_d;
            addr_q           <= addr_d;
            be_q             <= be_d;
            wdata_q          <= wdata_d;
            regwrite_wb_q    <= regwrite_wb_d;
            memtoreg_wb_q    <= memtoreg_wb_d;
            rtorrd_wb_q      <= rtorrd_wb_d;
            memdata_wb_q     <= memdata_wb_d;
            aluresult_wb_q   <= aluresult_wb_d;
            pcaddresult_wb_q <= pcaddresult_wb_d;
            align_err_q      <= align_err_d;
            bus_err_q        <= bus_err_d;
        end
    end

    // Stall is forced low during reset so every output reads 0 while held.
    assign Stall = Reset & (((state_q == S_IDLE) & mem & ~bad) | (state_q == S_WAIT));

    assign dmem_req       = req_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_be        = be_q;
    assign dmem_wdata     = wdata_q;
    assign RegWrite_wb    = regwrite_wb_q;
    assign MemtoReg_wb    = memtoreg_wb_q;
    assign RTorRd_wb      = rtorrd_wb_q;
    assign MemData_wb     = memdata_wb_q;
    assign ALUResult_wb   = aluresult_wb_q;
    assign PCAddResult_wb = pcaddresult_wb_q;
    assign align_err      = align_err_q;
    assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    localparam int unsigned TO = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        RegWrite, MemRead, MemWrite;
    logic        loadhalf, loadbyte, storehalf, storebyte;
    logic [1:0]  MemtoReg;
    logic [4:0]  RTorRd;
    logic [31:0] ALUResult, WriteData, PCAddResult;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        Stall;
    logic        RegWrite_wb;
    logic [1:0]  MemtoReg_wb;
    logic [4:0]  RTorRd_wb;
    logic [31:0] MemData_wb, ALUResult_wb, PCAddResult_wb;
    logic        align_err, bus_err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset(Reset),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .loadhalf(loadhalf), .loadbyte(loadbyte),
        .storehalf(storehalf), .storebyte(storebyte),
        .MemtoReg(MemtoReg), .RTorRd(RTorRd), .ALUResult(ALUResult),
        .WriteData(WriteData), .PCAddResult(PCAddResult),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .Stall(Stall), .RegWrite_wb(RegWrite_wb), .MemtoReg_wb(MemtoReg_wb),
        .RTorRd_wb(RTorRd_wb), .MemData_wb(MemData_wb),
        .ALUResult_wb(ALUResult_wb), .PCAddResult_wb(PCAddResult_wb),
        .align_err(align_err), .bus_err(bus_err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: expected store enables / data, sized by plain arithmetic.
    function automatic logic [3:0] ref_be(input int size, input logic [31:0] a);
        int lane = int'(a % 4);
        if (size == 2) return 4'(1 << lane);
        if (size == 1) return (lane >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input int size, input logic [31:0] d);
        if (size == 2) return (d & 32'hFF) * 32'h0101_0101;
        if (size == 1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input int size, input logic [31:0] a, input logic [31:0] r);
        logic [31:0] v;
        if (size == 2) begin
            v = (r >> (8 * (a % 4))) & 32'hFF;
            if (v >= 32'h80) v = v - 32'h100;
            return v;
        end
        if (size == 1) begin
            v = (r >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (v >= 32'h8000) v = v - 32'h1_0000;
            return v;
        end
        return r;
    endfunction

    function automatic bit ref_bad(input bit rd, input bit wr, input int size, input logic [31:0] a);
        if (rd && wr) return 1'b1;
        if (size == 0) return (a % 4) != 0;
        if (size == 1) return (a % 2) != 0;
        return 1'b0;
    endfunction

    task automatic idle_inputs();
        RegWrite = 0; MemRead = 0; MemWrite = 0;
        loadhalf = 0; loadbyte = 0; storehalf = 0; storebyte = 0;
        MemtoReg = 0; RTorRd = 0; ALUResult = 0; WriteData = 0; PCAddResult = 0;
        dmem_ack = 0; dmem_rdata = 0;
    endtask

    // One instruction through the stage. Entered and left just after a
    // rising edge; registered outputs are checked #1 after each edge.
    // size: 0 word, 1 half, 2 byte. delay: WAIT cycles before ack.
    task automatic run_op(input bit rd, input bit wr, input int size,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input int delay, input bit rw,
                          input logic [1:0] mtr, input logic [4:0] rt,
                          input logic [31:0] pc);
        bit mem = rd | wr;
        bit bad = ref_bad(rd, wr, size, addr);
        int stalls = 0;
        int exp_stalls;
        bit done = 0;
        RegWrite = rw; MemRead = rd; MemWrite = wr;
        loadhalf = rd && size == 1; loadbyte = rd && size == 2;
        storehalf = wr && size == 1; storebyte = wr && size == 2;
        MemtoReg = mtr; RTorRd = rt; ALUResult = addr; WriteData = wd; PCAddResult = pc;
        dmem_ack = 0; dmem_rdata = 0;

        @(negedge Clk);
        check("stall_issue", Stall, mem && !bad);
        if (Stall) stalls++;
        @(posedge Clk); #1;
        if (!mem) begin
            check("alu_regwrite", RegWrite_wb, rw);
            check("alu_rtorrd", RTorRd_wb, rt);
            check("alu_result", ALUResult_wb, addr);
            check("alu_pc", PCAddResult_wb, pc);
            check("alu_memtoreg", MemtoReg_wb, mtr);
            check("alu_memdata", MemData_wb, 0);
            check("alu_align", align_err, 0);
            return;
        end
        if (bad) begin
            check("bad_req", dmem_req, 0);
            check("bad_align", align_err, 1);
            check("bad_regwrite", RegWrite_wb, 0);
            check("bad_result", ALUResult_wb, 0);
            return;
        end
        check("req_up", dmem_req, 1);
        check("req_we", dmem_we, wr);
        check("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
        check("req_be", dmem_be, wr ? ref_be(size, addr) : 4'h0);
        check("req_wdata", dmem_wdata, wr ? ref_wdata(size, wd) : 32'h0);
        check("issue_bubble", RegWrite_wb, 0);

        for (int k = 0; k < 64 && !done; k++) begin
            if (k == delay) begin
                dmem_ack = 1; dmem_rdata = rdata;
            end
            @(negedge Clk);
            if (Stall) stalls++;
            @(posedge Clk); #1;
            if (k == delay) begin
                dmem_ack = 0; dmem_rdata = 32'hDEAD_BEEF;
                check("done_req", dmem_req, 0);
                check("done_regwrite", RegWrite_wb, wr ? 0 : rw);
                check("done_memdata", MemData_wb, rd ? ref_load(size, addr, rdata) : 32'h0);
                check("done_result", ALUResult_wb, addr);
                check("done_rt", RTorRd_wb, rt);
                check("done_pc", PCAddResult_wb, pc);
                check("done_buserr", bus_err, 0);
                done = 1;
            end else if (k == TO - 1) begin
                check("to_req", dmem_req, 0);
                check("to_buserr", bus_err, 1);
                check("to_bubble", RegWrite_wb, 0);
                check("to_memdata", MemData_wb, 0);
                done = 1;
            end else begin
                check("wait_req", dmem_req, 1);
                check("wait_addr", dmem_addr, addr & 32'hFFFF_FFFC);
            end
        end
        if (!done) check("wait_bound", 0, 1);

        exp_stalls = 1 + ((delay < TO) ? delay + 1 : TO);
        @(negedge Clk);
        check("resp_stall", Stall, 0);
        check("stall_cycles", stalls, exp_stalls);
        @(posedge Clk); #1;
        check("resp_bubble", RegWrite_wb, 0);
        check("resp_req", dmem_req, 0);
        check("resp_pulses", {align_err, bus_err}, 0);
    endtask

    initial begin
        idle_inputs();
        Reset = 0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_req", dmem_req, 0);
        check("rst_stall", Stall, 0);
        check("rst_wb", {RegWrite_wb, MemtoReg_wb, RTorRd_wb}, 0);
        check("rst_memdata", MemData_wb, 0);
        check("rst_errs", {align_err, bus_err}, 0);
        Reset = 1;
        @(posedge Clk); #1;

        // Directed cases.
        run_op(0, 0, 0, 32'h0000_1234, 0, 0, 0, 1, 2'd0, 5'd5, 32'h0000_0404);
        run_op(1, 0, 2, 32'h0000_0103, 0, 32'h80FF_0000, 2, 1, 2'd1, 5'd7, 32'h0000_0408);
        run_op(0, 1, 1, 32'h0000_0102, 32'hAAAA_BEEF, 0, 1, 1, 2'd0, 5'd3, 32'h0000_040C);
        run_op(1, 0, 0, 32'h0000_0101, 0, 0, 0, 1, 2'd1, 5'd9, 32'h0000_0410);
        run_op(1, 0, 0, 32'h0000_0200, 0, 32'h1234_5678, 99, 1, 2'd1, 5'd4, 32'h0000_0414);
        run_op(1, 0, 0, 32'h0000_0204, 0, 32'hCAFE_F00D, TO - 1, 1, 2'd1, 5'd6, 32'h0000_0418);
        run_op(1, 1, 0, 32'h0000_0300, 0, 0, 0, 1, 2'd1, 5'd2, 32'h0000_041C);

        // Randomized instruction mix.
        for (int i = 0; i < 80; i++) begin
            int kind = int'($urandom_range(0, 7));
            int size = int'($urandom_range(0, 2));
            bit rd = (kind == 1 || kind == 2 || kind == 3 || kind == 7);
            bit wr = (kind == 4 || kind == 5 || kind == 7);
            logic [31:0] a = $urandom;
            if (kind != 3 && kind != 5 && kind != 7) begin
                // Mostly legal addresses; occasional misalignment.
                a = a & ((size == 0) ? 32'hFFFF_FFFC : (size == 1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
            end
            run_op(rd, wr, size, a, $urandom, $urandom, int'($urandom_range(0, 5)),
                   1'($urandom), 2'($urandom), 5'($urandom), $urandom);
        end

        // Reset asserted while an access is outstanding.
        RegWrite = 1; MemRead = 1; MemWrite = 0;
        loadhalf = 0; loadbyte = 0; storehalf = 0; storebyte = 0;
        ALUResult = 32'h0000_0800; RTorRd = 5'd8;
        @(posedge Clk); #1;
        check("mid_req_up", dmem_req, 1);
        @(posedge Clk); #2;
        Reset = 0;
        #1;
        check("mid_req_drop", dmem_req, 0);
        check("mid_stall", Stall, 0);
        check("mid_bus", {dmem_we, dmem_be, dmem_addr}, 0);
        check("mid_wb", {RegWrite_wb, RTorRd_wb, ALUResult_wb}, 0);
        check("mid_errs", {align_err, bus_err}, 0);
        idle_inputs();
        @(negedge Clk);
        Reset = 1;
        @(posedge Clk); #1;
        check("post_req", dmem_req, 0);
        check("post_errs", {align_err, bus_err}, 0);
        run_op(0, 0, 0, 32'h0000_5678, 0, 0, 0, 1, 2'd2, 5'd11, 32'h0000_0500);
        run_op(0, 1, 2, 32'h0000_0601, 32'h1234_56A5, 0, 0, 0, 2'd0, 5'd0, 32'h0000_0504);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
